// File: rtl/triggerrec_event_arbiter.sv
// triggerrec_event_arbiter
// Shares the events-FIFO write port between NUM_REQ trigger-match units.
// Each unit owns a one-entry holding register. Pending entries are granted
// round-robin and written as one 64-bit word {idx[3:0], tag[11:0], ts[47:0]}.
// Events that arrive at an occupied holding register are dropped and counted.
// Optional build macro: TRIGGERREC_ARB_PRIO_EN gives requester 0 absolute
// priority over the round-robin group.

module triggerrec_event_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned TAG_WIDTH = 12,
   parameter int unsigned TS_WIDTH  = 48
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          enable,
   input  logic                          clr_drops,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*TS_WIDTH-1:0]   req_ts,
   input  logic                          fifo_full,
   output logic                          fifo_wr,
   output logic [63:0]                   fifo_wdata,
   output logic [NUM_REQ-1:0]            pending,
   output logic                          busy,
   output logic [15:0]                   drop_count,
   output logic [1:0]                    state
);

   localparam int unsigned IDX_W   = 4;
   localparam int unsigned MAX_REQ = 16;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DCNT_W  = 5;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0]     idx;
      logic [TAG_WIDTH-1:0] tag;
      logic [TS_WIDTH-1:0]  ts;
   } event_word_t;

   state_t               state_q,  state_d;
   logic [NUM_REQ-1:0]   pending_q, pending_d;
   logic [IDX_W-1:0]     ptr_q,    ptr_d;
   logic                 fifo_wr_q, fifo_wr_d;
   event_word_t          wdata_q,  wdata_d;
   logic [CNT_W-1:0]     drop_q,   drop_d;
   logic                 busy_q,   busy_d;

   logic [TAG_WIDTH-1:0] tag_q [NUM_REQ];
   logic [TS_WIDTH-1:0]  ts_q  [NUM_REQ];

   logic                 grant_vld_c;
   logic [IDX_W-1:0]     grant_idx_c;
   logic [NUM_REQ-1:0]   grant_oh_c;
   logic [NUM_REQ-1:0]   cap_c;
   logic [NUM_REQ-1:0]   drop_c;
   logic [DCNT_W-1:0]    drop_cnt_c;
   logic [CNT_W:0]       drop_sum_c;
   logic [MAX_REQ-1:0]   pend_ext_c;
   logic [IDX_W-1:0]     cand_c;

   // Arbitration: first pending slot after the pointer, optionally with requester 0 first
   always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      cand_c      = '0;
      pend_ext_c  = MAX_REQ'(pending_q);
      if ((state_q != ST_DISABLED) && (|pending_q) && !fifo_full) begin
`ifdef TRIGGERREC_ARB_PRIO_EN
         if (pending_q[0]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = '0;
         end
`endif
         for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand_c = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld_c && pend_ext_c[cand_c]) begin
               grant_vld_c = 1'b1;
               grant_idx_c = cand_c;
            end
         end
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         grant_oh_c[i] = grant_vld_c && (grant_idx_c == IDX_W'(i));
      end
   end

   // Capture / drop decision per requester and saturating drop total
   always_comb begin
      cap_c      = '0;
      drop_c     = '0;
      drop_cnt_c = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if ((state_q == ST_RUN) && req_valid[i]) begin
            if (!pending_q[i] || grant_oh_c[i]) begin
               cap_c[i] = 1'b1;
            end else begin
               drop_c[i] = 1'b1;
            end
         end
         drop_cnt_c = drop_cnt_c + DCNT_W'(drop_c[i]);
      end
      drop_sum_c = (CNT_W+1)'(drop_q) + (CNT_W+1)'(drop_cnt_c);
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ptr_d     = ptr_q;
      fifo_wr_d = 1'b0;
      wdata_d   = wdata_q;
      drop_d    = drop_q;

      case (state_q)
         ST_DISABLED: if (enable) state_d = ST_RUN;
         ST_RUN:      if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)               state_d = ST_RUN;
            else if (pending_q == '0) state_d = ST_DISABLED;
         end
         default:     state_d = ST_DISABLED;
      endcase

      if (grant_vld_c) begin
         fifo_wr_d   = 1'b1;
         wdata_d.idx = grant_idx_c;
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_oh_c[i]) begin
               wdata_d.tag = tag_q[i];
               wdata_d.ts  = ts_q[i];
            end
         end
`ifdef TRIGGERREC_ARB_PRIO_EN
         if (grant_idx_c != '0) ptr_d = grant_idx_c;
`else
         ptr_d = grant_idx_c;
`endif
      end

      pending_d = (pending_q & ~grant_oh_c) | cap_c;

      if (clr_drops)                         drop_d = '0;
      else if (drop_sum_c > (CNT_W+1)'(17'h0FFFF)) drop_d = '1;
      else                                   drop_d = drop_sum_c[CNT_W-1:0];

      busy_d = (|pending_d) | fifo_wr_d;
   end

   // Control and output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= ST_DISABLED;
         pending_q <= '0;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
         fifo_wr_q <= 1'b0;
         wdata_q   <= '0;
         drop_q    <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         fifo_wr_q <= fifo_wr_d;
         wdata_q   <= wdata_d;
         drop_q    <= drop_d;
         busy_q    <= busy_d;
      end
   end

   // Holding-register payload; validity is tracked by pending_q so no reset needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (cap_c[i]) begin
            tag_q[i] <= req_tag[TAG_WIDTH*i +: TAG_WIDTH];
            ts_q[i]  <= req_ts[TS_WIDTH*i +: TS_WIDTH];
         end
      end
   end

   assign fifo_wr    = fifo_wr_q;
   assign fifo_wdata = wdata_q;
   assign pending    = pending_q;
   assign busy       = busy_q;
   assign drop_count = drop_q;
   assign state      = state_q;

endmodule

// File: tb/tb_triggerrec_event_arbiter.sv
// Bench for triggerrec_event_arbiter: directed scenarios plus random traffic,
// checked against a per-cycle behavioural model through a write scoreboard.

module tb_triggerrec_event_arbiter;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic            enable;
   logic            clr_drops;
   logic [N-1:0]    req_valid;
   logic [N*12-1:0] req_tag;
   logic [N*48-1:0] req_ts;
   logic            fifo_full;
   logic            fifo_wr;
   logic [63:0]     fifo_wdata;
   logic [N-1:0]    pending;
   logic            busy;
   logic [15:0]     drop_count;
   logic [1:0]      state;

   triggerrec_event_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .clr_drops(clr_drops),
      .req_valid(req_valid), .req_tag(req_tag), .req_ts(req_ts),
      .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
      .pending(pending), .busy(busy), .drop_count(drop_count), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_wr   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_pend [16];
   logic [11:0] m_tag  [16];
   logic [47:0] m_ts   [16];
   int          m_ptr  = N - 1;
   int          m_st   = 0;
   int          m_dc   = 0;
   bit          m_wr   = 1'b0;
   logic [63:0] m_wdata = '0;
   logic [63:0] exp_q[$];

   always @(posedge clk) begin
      int  g;
      int  drops;
      bit  any;
      bit  old_pend [16];
      if (!resetn) begin
         for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
         m_ptr = N - 1; m_st = 0; m_dc = 0; m_wr = 1'b0; m_wdata = '0;
      end else begin
         old_pend = m_pend;
         any = 1'b0;
         for (int i = 0; i < N; i++) any |= m_pend[i];
         g = -1;
         if (m_st != 0 && any && !fifo_full) begin
`ifdef TRIGGERREC_ARB_PRIO_EN
            if (m_pend[0]) g = 0;
`endif
            for (int k = 1; k <= N; k++)
               if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         m_wr = (g >= 0);
         if (g >= 0) begin
            m_wdata = {4'(g), m_tag[g], m_ts[g]};
            exp_q.push_back(m_wdata);
            m_pend[g] = 1'b0;
`ifdef TRIGGERREC_ARB_PRIO_EN
            if (g != 0) m_ptr = g;
`else
            m_ptr = g;
`endif
         end
         drops = 0;
         if (m_st == 1) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i]) begin
                  if (!old_pend[i] || i == g) begin
                     m_pend[i] = 1'b1;
                     m_tag[i]  = req_tag[12*i +: 12];
                     m_ts[i]   = req_ts[48*i +: 48];
                  end else drops++;
               end
            end
         end
         if (clr_drops) m_dc = 0;
         else m_dc = (m_dc + drops > 65535) ? 65535 : m_dc + drops;
         case (m_st)
            0: if (enable) m_st = 1;
            1: if (!enable) m_st = 2;
            default: if (enable) m_st = 1; else if (!any) m_st = 0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [N-1:0] ep;
      logic [63:0]  e;
      bit           eany;
      eany = 1'b0;
      for (int i = 0; i < N; i++) begin ep[i] = m_pend[i]; eany |= m_pend[i]; end
      chk("fifo_wr", 64'(fifo_wr), 64'(m_wr));
      chk("pending", 64'(pending), 64'(ep));
      chk("drop_count", 64'(drop_count), 64'(m_dc));
      chk("state", 64'(state), 64'(m_st));
      chk("busy", 64'(busy), 64'(eany | m_wr));
      chk("fifo_wdata_hold", fifo_wdata, m_wdata);
      if (fifo_wr) begin
         n_wr++;
         if (exp_q.size() == 0) chk("unexpected_write", 64'(fifo_wr), 64'(0));
         else begin
            e = exp_q.pop_front();
            chk("write_word", fifo_wdata, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic rand_payload();
      for (int i = 0; i < N; i++) begin
         req_tag[12*i +: 12] = 12'($urandom);
         req_ts[48*i +: 48]  = {16'($urandom), 32'($urandom)};
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [47:0] first_ts;
      int          wr0;
      int          budget;

      resetn = 1'b0; enable = 1'b0; clr_drops = 1'b0; req_valid = '0;
      fifo_full = 1'b0; rand_payload();
      repeat (3) step();
      chk("reset_fifo_wr", 64'(fifo_wr), 64'(0));
      chk("reset_pending", 64'(pending), 64'(0));
      chk("reset_drops", 64'(drop_count), 64'(0));
      chk("reset_state", 64'(state), 64'(0));
      chk("reset_wdata", fifo_wdata, 64'(0));

      // single event latency
      resetn = 1'b1; enable = 1'b1; step();
      chk("t1_state_run", 64'(state), 64'(1));
      rand_payload();
      req_valid = 4'b0100; req_tag[24 +: 12] = 12'h5A1; req_ts[96 +: 48] = 48'h0000_0000_1234;
      step(); req_valid = '0;
      chk("t1_no_wr_n1", 64'(fifo_wr), 64'(0));
      chk("t1_captured", 64'(pending), 64'(4'b0100));
      step();
      chk("t1_wr_n2", 64'(fifo_wr), 64'(1));
      chk("t1_word", fifo_wdata, 64'h25A1_0000_0000_1234);
      chk("t1_drops", 64'(drop_count), 64'(0));

      // all four at once from pointer=3
      resetn = 1'b0; step();
      resetn = 1'b1; step();
      rand_payload(); req_valid = 4'b1111; step(); req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_wr", 64'(fifo_wr), 64'(1));
         chk("t2_idx", 64'(fifo_wdata[63:60]), 64'(i));
      end
      step();
      chk("t2_busy_low", 64'(busy), 64'(0));
      chk("t2_drops", 64'(drop_count), 64'(0));

      // fifo_full blocks, repeated strobes drop
      fifo_full = 1'b1;
      rand_payload(); first_ts = req_ts[48 +: 48];
      req_valid = 4'b0010; step(); req_valid = '0; step();
      rand_payload(); req_valid = 4'b0010; step(); req_valid = '0; step();
      rand_payload(); req_valid = 4'b0010; step(); req_valid = '0;
      chk("t3_drops2", 64'(drop_count), 64'(2));
      chk("t3_held", 64'(pending), 64'(4'b0010));
      fifo_full = 1'b0; step();
      chk("t3_wr", 64'(fifo_wr), 64'(1));
      chk("t3_first_ts", 64'(fifo_wdata[47:0]), 64'(first_ts));
      step();

      // drop counter saturation and clear
      fifo_full = 1'b1; clr_drops = 1'b1; rand_payload(); req_valid = 4'b1111; step();
      clr_drops = 1'b0;
      repeat (16383) begin rand_payload(); step(); end
      chk("t4_fffc", 64'(drop_count), 64'(16'hFFFC));
      req_valid = 4'b0011; step();
      chk("t4_fffe", 64'(drop_count), 64'(16'hFFFE));
      req_valid = 4'b0110; step();
      chk("t4_sat", 64'(drop_count), 64'(16'hFFFF));
      req_valid = 4'b1111; step();
      chk("t4_sat_hold", 64'(drop_count), 64'(16'hFFFF));
      clr_drops = 1'b1; step();
      chk("t4_clr", 64'(drop_count), 64'(0));
      clr_drops = 1'b0; req_valid = '0; fifo_full = 1'b0;
      repeat (6) step();
      chk("t4_idle", 64'(busy), 64'(0));

      // drain on disable
      fifo_full = 1'b1; rand_payload(); req_valid = 4'b1010; step(); req_valid = '0;
      wr0 = n_wr;
      enable = 1'b0; fifo_full = 1'b0; step();
      chk("t5_drain", 64'(state), 64'(2));
      rand_payload(); req_valid = 4'b1111; step(); req_valid = '0;
      budget = 20;
      while (state != 2'd0 && budget > 0) begin step(); budget--; end
      chk("t5_disabled", 64'(state), 64'(0));
      step(); step();
      chk("t5_writes", 64'(n_wr - wr0), 64'(2));
      chk("t5_no_drop", 64'(drop_count), 64'(0));

      // requester 0 streaming against pending 1..3
      enable = 1'b1; step();
      fifo_full = 1'b1; rand_payload(); req_valid = 4'b1111; step();
      fifo_full = 1'b0;
      repeat (6) begin rand_payload(); req_valid = 4'b0001; step(); end
      req_valid = '0;
      repeat (8) step();

      // random traffic
      repeat (4000) begin
         resetn    = ($urandom % 500) != 0;
         enable    = ($urandom % 16) != 0;
         fifo_full = ($urandom % 4) == 0;
         clr_drops = ($urandom % 64) == 0;
         req_valid = 4'($urandom) & 4'($urandom);
         rand_payload();
         step();
      end
      resetn = 1'b1; enable = 1'b1; fifo_full = 1'b0; clr_drops = 1'b0; req_valid = '0;
      repeat (20) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/triggerrec_event_arbiter.md
Name: triggerrec_event_arbiter

Overview:
Shares the single write port of the trigger recorder's 64-bit event FIFO between NUM_REQ trigger-match units.
- Each unit gets a one-entry holding register.
- Pending entries are granted round-robin and written as one 64-bit event word.
- Events arriving while a unit's holding register is occupied are dropped and counted.
- Sits between the trigger comparators and the events FIFO in the recorder module, in the ctrl clock domain.

Parameters:
NUM_REQ, 4, number of requesters; legal 1..16.
TAG_WIDTH, 12, per-event tag width (trigger id / pin snapshot); fixed at 12 so the event word is 64 bits.
TS_WIDTH, 48, timestamp width; fixed at 48.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
enable  in  1  1 = accept new events; 0 = stop accepting and drain pending entries
clr_drops  in  1  single-cycle pulse that clears drop_count
req_valid  in  NUM_REQ  per-requester event strobe, one cycle per event
req_tag  in  NUM_REQ*12  per-requester tag; slice i = [12*i+11:12*i]
req_ts  in  NUM_REQ*48  per-requester timestamp; slice i = [48*i+47:48*i]
fifo_full  in  1  events FIFO full
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  64  event word {idx[3:0], tag[11:0], ts[47:0]}
pending  out  NUM_REQ  holding-register valid bits
busy  out  1  OR of pending, or fifo_wr asserted
drop_count  out  16  saturating count of dropped events
state  out  2  FSM state, for debug

Behaviour:
- Reset (resetn low at a clk edge): fifo_wr=0, fifo_wdata=0, pending=0, drop_count=0, round-robin pointer=NUM_REQ-1, state=DISABLED(0).
- FSM states: DISABLED=0, RUN=1, DRAIN=2.
  - DISABLED -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> DISABLED when pending=0; DRAIN -> RUN if enable returns to 1.
- Capture happens only in RUN. In DISABLED and DRAIN, req_valid is ignored and not counted as a drop.
- Capture rule, for requester i with req_valid[i]=1 in RUN:
  - If pending[i]=0, or pending[i]=1 and i is granted this cycle: tag and ts are loaded and pending[i]=1 on the next cycle.
  - Otherwise the event is dropped.
- Drop counting: drop_count increases by the number of requesters dropping in that cycle, saturating at 16'hFFFF.
  - clr_drops has priority over increments in the same cycle; the result is 0.
- Arbitration, every cycle in RUN or DRAIN when pending≠0 and fifo_full=0:
  - Grant the first pending index searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Next cycle: fifo_wr=1 for exactly one cycle, fifo_wdata={grant_idx, tag, ts}, pending[grant] cleared, pointer=grant_idx.
- No grant while fifo_full=1. Pending entries hold, and new events to occupied slots drop.
- Latency: req_valid at cycle N, slot free, FIFO not full, no competition -> fifo_wr at cycle N+2 (N+1 capture register, N+1 grant, N+2 write).
- Throughput: at most one event per cycle.
- fifo_wdata holds its last value when fifo_wr=0.
- The index field is zero-extended to 4 bits.
- Reset mid-operation: all pending entries are discarded and no fifo_wr is issued in the cycle after reset.

Optional Feature:
TRIGGERREC_ARB_PRIO_EN
- Defined: requester 0 has fixed absolute priority. Whenever pending[0]=1 it is granted, and the pointer is not updated by a requester-0 grant. Remaining requesters are round-robin among themselves.
- Undefined: pure round-robin as described above.

Test Plan:
- Reset, enable=1, single req_valid[2] with tag=12'h5A1, ts=48'h0000_0000_1234 at cycle N -> fifo_wr at N+2 with fifo_wdata=64'h25A1_0000_0000_1234; drop_count=0.
- req_valid=4'b1111 in one cycle with pointer=3 -> four consecutive fifo_wr cycles with idx 0,1,2,3; no drops; busy falls after the last write.
- fifo_full=1 held, requester 1 strobes 3 times on separate cycles -> first captured, 2 drops, drop_count=2. Release fifo_full -> one write with the first event's ts.
- drop_count at 16'hFFFE, two requesters drop in the same cycle -> 16'hFFFF (saturates). clr_drops pulse -> 0.
- enable dropped with 2 entries pending -> state goes to DRAIN, both entries are written, then state=DISABLED. req_valid during DRAIN produces no write and no drop.
- With TRIGGERREC_ARB_PRIO_EN: requester 0 strobes every cycle while requesters 1..3 are pending -> all requester-0 events written before any other. Without the macro, grants alternate.
